// File: rtl/hazard_pkg.sv
// Shared types for the ID-stage hazard detection unit: FSM states and hazard classes.
// Combinational content only; no latency, no backpressure.
package hazard_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    // Hazard classes: H3 (load feeding a branch) is the only one needing two stall cycles.
    typedef enum logic [2:0] {
        NONE = 3'd0,
        H1   = 3'd1,
        H2   = 3'd2,
        H3   = 3'd3,
        H4   = 3'd4
    } hazard_class_t;

    localparam int REG_ZERO = 0;

endpackage

// File: rtl/hazard_perf_counter.sv
// Event counter that wraps modulo 2^CNT_W; used for stall/flush statistics.
// Count visible one cycle after inc; no backpressure.
module hazard_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (inc)
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_detection_unit.sv
// Load-use / ALU-to-branch / load-to-branch stall and branch-flush control for a 5-stage MIPS pipeline (optional counters: HAZARD_PERF_CNT_EN).
// Mealy: stall/flush asserted in the same cycle the hazard is seen; H3 holds one extra cycle; stall overrides flush.
module hazard_detection_unit
    import hazard_pkg::*;
#(
    parameter int REG_AW = 5
`ifdef HAZARD_PERF_CNT_EN
  , parameter int CNT_W  = 32
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [REG_AW-1:0] id_rs,
    input  logic [REG_AW-1:0] id_rt,
    input  logic              id_use_rs,
    input  logic              id_use_rt,
    input  logic              id_is_branch,
    input  logic              branch_taken,
    input  logic              idex_mem_read,
    input  logic              idex_reg_write,
    input  logic [REG_AW-1:0] idex_rd,
    input  logic              exmem_mem_read,
    input  logic [REG_AW-1:0] exmem_rd,
    output logic              pc_write,
    output logic              if_id_write,
    output logic              id_ex_bubble,
    output logic              if_id_flush,
    output logic              stall
`ifdef HAZARD_PERF_CNT_EN
  , output logic [CNT_W-1:0]  stall_cnt,
    output logic [CNT_W-1:0]  flush_cnt
`endif
);

    state_t        state;
    hazard_class_t hz_class;
    logic          dep_ex;
    logic          dep_mem;

    function automatic logic dep(input logic use_x,
                                 input logic [REG_AW-1:0] x,
                                 input logic [REG_AW-1:0] r);
        return use_x && (x == r) && (r != REG_AW'(REG_ZERO));
    endfunction

    assign dep_ex  = dep(id_use_rs, id_rs, idex_rd)  || dep(id_use_rt, id_rt, idex_rd);
    assign dep_mem = dep(id_use_rs, id_rs, exmem_rd) || dep(id_use_rt, id_rt, exmem_rd);

    always_comb begin
        hz_class = NONE;
        if (id_is_branch && idex_mem_read && dep_ex)
            hz_class = H3;
        else if (idex_mem_read && dep_ex)
            hz_class = H1;
        else if (id_is_branch && idex_reg_write && !idex_mem_read && dep_ex)
            hz_class = H2;
        else if (id_is_branch && exmem_mem_read && dep_mem)
            hz_class = H4;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= IDLE;
        else if (state == IDLE && hz_class == H3)
            state <= HOLD;
        else
            state <= IDLE;
    end

    // Reset gates the Mealy path so a reset during HOLD releases the pipeline at once.
    assign stall        = !rst && ((state == HOLD) || (hz_class != NONE));
    assign pc_write     = !stall;
    assign if_id_write  = !stall;
    assign id_ex_bubble = stall;
    assign if_id_flush  = !rst && id_is_branch && branch_taken && !stall;

    always_ff @(posedge clk) begin
        if (!rst)
            assert (!(if_id_flush && id_ex_bubble))
                else $error("flush and bubble asserted together");
    end

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (stall),
        .cnt (stall_cnt)
    );

    hazard_perf_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (if_id_flush),
        .cnt (flush_cnt)
    );
`endif

endmodule

// File: tb/tb_hazard_detection_unit.sv
// Directed-vector bench for hazard_detection_unit; counter checks compile in with HAZARD_PERF_CNT_EN.
module tb_hazard_detection_unit;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs, id_rt, idex_rd, exmem_rd;
    logic       id_use_rs, id_use_rt, id_is_branch, branch_taken;
    logic       idex_mem_read, idex_reg_write, exmem_mem_read;
    logic       pc_write, if_id_write, id_ex_bubble, if_id_flush, stall;
`ifdef HAZARD_PERF_CNT_EN
    logic [31:0] stall_cnt, flush_cnt;
    logic        w_rst, w_inc;
    logic [3:0]  w_cnt;
`endif

    int chk_cnt = 0;
    int err_cnt = 0;

    // {pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}
    localparam logic [4:0] RUN   = 5'b11000;
    localparam logic [4:0] STALL = 5'b00101;
    localparam logic [4:0] FLUSH = 5'b11010;

    always #5 clk = ~clk;

    hazard_detection_unit dut (
        .clk            (clk),
        .rst            (rst),
        .id_rs          (id_rs),
        .id_rt          (id_rt),
        .id_use_rs      (id_use_rs),
        .id_use_rt      (id_use_rt),
        .id_is_branch   (id_is_branch),
        .branch_taken   (branch_taken),
        .idex_mem_read  (idex_mem_read),
        .idex_reg_write (idex_reg_write),
        .idex_rd        (idex_rd),
        .exmem_mem_read (exmem_mem_read),
        .exmem_rd       (exmem_rd),
        .pc_write       (pc_write),
        .if_id_write    (if_id_write),
        .id_ex_bubble   (id_ex_bubble),
        .if_id_flush    (if_id_flush),
        .stall          (stall)
`ifdef HAZARD_PERF_CNT_EN
      , .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
`endif
    );

`ifdef HAZARD_PERF_CNT_EN
    hazard_perf_counter #(.CNT_W(4)) u_wrap (
        .clk (clk),
        .rst (w_rst),
        .inc (w_inc),
        .cnt (w_cnt)
    );
`endif

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // ID fields: rs, rt, use_rs, use_rt, is_branch, taken; EX: mem_read, reg_write, rd; MEM: mem_read, rd
    task automatic drive(input logic [4:0] rs, input logic [4:0] rt, input logic urs, input logic urt,
                         input logic br, input logic tk,
                         input logic exmr, input logic exrw, input logic [4:0] exrd,
                         input logic memr, input logic [4:0] memrd);
        id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
        id_is_branch = br; branch_taken = tk;
        idex_mem_read = exmr; idex_reg_write = exrw; idex_rd = exrd;
        exmem_mem_read = memr; exmem_rd = memrd;
    endtask

    // Checks the settled outputs for the current cycle, then advances one clock.
    task automatic cyc(input string tag, input logic [4:0] exp);
        #1;
        check(tag, 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}), 32'(exp));
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        drive(5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
    endtask

    // lw $2 in EX, add uses rs=2; load then advances to MEM with a bubble behind it
    task automatic test_load_use();
        drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
        cyc("t1_stall", STALL);
        drive(5'd2, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd2);
        cyc("t1_release", RUN);
    endtask

    // lw $4 in EX, beq rt=4 taken: two stalls, no flush while stalled
    task automatic test_load_branch();
        drive(5'd7, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0);
        cyc("t3_stall0", STALL);
        drive(5'd7, 5'd4, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b1, 5'd4);
        cyc("t3_hold", STALL);
        drive(5'd7, 5'd4, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        cyc("t3_release", RUN);
    endtask

    // add $5 in EX, beq rs=5: one stall, then taken -> single flush
    task automatic test_alu_branch();
        drive(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        cyc("t4_stall", STALL);
        drive(5'd5, 5'd6, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 1'b0, 5'd5);
        cyc("t4_flush", FLUSH);
        idle_inputs();
        cyc("t4_after", RUN);
    endtask

    initial begin
        rst = 1'b1;
        // hazard present during reset must still produce reset outputs
        drive(5'd2, 5'd0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
`ifdef HAZARD_PERF_CNT_EN
        w_rst = 1'b1; w_inc = 1'b0;
`endif
        @(posedge clk);
        #1;
        check("reset_outs", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}), 32'(RUN));
        @(negedge clk);
        idle_inputs();
        rst = 1'b0;
        @(posedge clk);
        #1;

        test_load_use();
        test_load_branch();
        test_alu_branch();
`ifdef HAZARD_PERF_CNT_EN
        check("stall_cnt", stall_cnt, 32'd4);
        check("flush_cnt", flush_cnt, 32'd1);
`endif

        // register 0 as load destination never stalls
        drive(5'd0, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd0, 1'b0, 5'd0);
        cyc("t2_reg0", RUN);
        // matching rs that the instruction does not read
        drive(5'd2, 5'd3, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd2, 1'b0, 5'd0);
        cyc("unused_rs", RUN);
        // load-use through rt
        drive(5'd1, 5'd9, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd9, 1'b0, 5'd0);
        cyc("h1_rt", STALL);
        idle_inputs();
        cyc("h1_rt_rel", RUN);
        // branch with load in MEM (H4): single stall
        drive(5'd8, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b1, 5'd8);
        cyc("h4_stall", STALL);
        drive(5'd8, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 5'd0, 1'b0, 5'd0);
        cyc("h4_rel", RUN);
        // ALU result to register 0 feeding branch: no hazard, taken branch flushes
        drive(5'd0, 5'd1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 5'd0, 1'b0, 5'd0);
        cyc("h2_reg0_flush", FLUSH);
        // non-branch after ALU producer: forwarding handles it
        drive(5'd5, 5'd1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 1'b0, 5'd0);
        cyc("alu_nobranch", RUN);

        // reset in the middle of HOLD drops the remaining stall
        drive(5'd4, 5'd1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd4, 1'b0, 5'd0);
        cyc("t5_stall0", STALL);
        idle_inputs();
        #1;
        check("t5_in_hold", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}), 32'(STALL));
        rst = 1'b1;
        #1;
        check("t5_rst_now", 32'({pc_write, if_id_write, id_ex_bubble, if_id_flush, stall}), 32'(RUN));
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc("t5_no_resume", RUN);

`ifdef HAZARD_PERF_CNT_EN
        @(negedge clk);
        w_rst = 1'b0;
        w_inc = 1'b1;
        repeat (15) @(posedge clk);
        #1;
        check("wrap_pre", 32'(w_cnt), 32'd15);
        @(posedge clk);
        #1;
        check("wrap_zero", 32'(w_cnt), 32'd0);
        w_inc = 1'b0;
`endif

        $display("CHECKS %0d ERRORS %0d", chk_cnt, err_cnt);
        $finish;
    end

endmodule
